// File: rtl/cache_arb_pkg.sv
// Shared types and default geometry for the two-client cache line arbiter.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_ICACHE,
        GNT_DCACHE
    } grant_t;

    localparam int ARB_LINE_BITS   = 256;
    localparam int ARB_BEAT_BITS   = 64;
    localparam int ARB_BURST_BEATS = ARB_LINE_BITS / ARB_BEAT_BITS;

endpackage

// File: rtl/mem_rw_itf.sv
// Line-granular read/write request interface between a cache and the arbiter.
interface mem_rw_itf #(
    parameter int LINE_BITS = 256
);
    logic                   read;
    logic                   write;
    logic [31:0]            addr;
    logic [LINE_BITS-1:0]   wdata;
    logic [LINE_BITS/8-1:0] wmask;
    logic [LINE_BITS-1:0]   rdata;
    logic                   resp;

    modport server (input read, write, addr, wdata, wmask, output rdata, resp);
    modport client (output read, write, addr, wdata, wmask, input rdata, resp);
endinterface

// File: rtl/line_burst_adapter.sv
// Splits a latched write line into beats and assembles read beats into a line,
// indexed by a beat counter that wraps after the last beat of a burst.
module line_burst_adapter
    import cache_arb_pkg::*;
#(
    parameter int LINE_BITS   = ARB_LINE_BITS,
    parameter int BEAT_BITS   = ARB_BEAT_BITS,
    parameter int BURST_BEATS = ARB_BURST_BEATS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 beat_i,
    input  logic                 capture_i,
    input  logic [LINE_BITS-1:0] wdata_i,
    input  logic [BEAT_BITS-1:0] rdata_beat_i,
    output logic [BEAT_BITS-1:0] wdata_beat_o,
    output logic [LINE_BITS-1:0] line_o,
    output logic                 last_beat_o
);

    localparam int CNT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_BEATS - 1);

    logic [CNT_W-1:0]     beat_q;
    logic [LINE_BITS-1:0] line_buf_q;
    logic [LINE_BITS-1:0] wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q     <= '0;
            line_buf_q <= '0;
        end else begin
            if (load_i) begin
                beat_q <= '0;
            end else if (beat_i) begin
                beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
            end
            if (capture_i) begin
                line_buf_q[int'(beat_q)*BEAT_BITS +: BEAT_BITS] <= rdata_beat_i;
            end
        end
    end

    // Write line is pure data: only meaningful after a load, so no reset needed.
    always_ff @(posedge clk) begin
        if (load_i) begin
            wdata_q <= wdata_i;
        end
    end

    assign wdata_beat_o = wdata_q[int'(beat_q)*BEAT_BITS +: BEAT_BITS];
    assign line_o       = line_buf_q;
    assign last_beat_o  = (beat_q == LAST_BEAT);

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates icache/dcache line requests onto one burst memory port.
// Define ARB_ROUND_ROBIN_EN for alternating grants; otherwise dcache has priority.
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int LINE_BITS   = ARB_LINE_BITS,
    parameter int BEAT_BITS   = ARB_BEAT_BITS,
    parameter int BURST_BEATS = ARB_BURST_BEATS
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_rw_itf.server            icache,
    mem_rw_itf.server            dcache,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [31:0]          pmem_addr,
    output logic [BEAT_BITS-1:0] pmem_wdata,
    input  logic [BEAT_BITS-1:0] pmem_rdata,
    input  logic                 pmem_resp
);

    localparam logic [31:0] OFFSET_MASK = 32'(LINE_BITS / 8 - 1);

    arb_state_t state_q;
    grant_t     grant_q;
    logic [31:0] addr_q;
    logic pmem_read_q, pmem_write_q;
    logic iresp_q, dresp_q;

    logic ireq, dreq, any_req, pick_d, sel_write;
    logic [31:0]          sel_addr;
    logic [LINE_BITS-1:0] sel_wdata;
    logic in_burst, last_beat;
    logic [LINE_BITS-1:0] line_buf;

    assign ireq    = icache.read | icache.write;
    assign dreq    = dcache.read | dcache.write;
    assign any_req = ireq | dreq;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q;
    assign pick_d = dreq & (~ireq | ~last_d_q);
`else
    assign pick_d = dreq;
`endif

    // Write wins over read when a client raises both.
    assign sel_write = pick_d ? dcache.write : icache.write;
    assign sel_addr  = pick_d ? dcache.addr  : icache.addr;
    assign sel_wdata = pick_d ? dcache.wdata : icache.wdata;
    assign in_burst  = (state_q == RD_BURST) || (state_q == WR_BURST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= GNT_NONE;
            addr_q       <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            iresp_q      <= 1'b0;
            dresp_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q      <= pick_d ? GNT_DCACHE : GNT_ICACHE;
                        addr_q       <= sel_addr & ~OFFSET_MASK;
                        pmem_write_q <= sel_write;
                        pmem_read_q  <= ~sel_write;
                        state_q      <= sel_write ? WR_BURST : RD_BURST;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d_q     <= pick_d;
`endif
                    end
                end
                RD_BURST, WR_BURST: begin
                    if (pmem_resp && last_beat) begin
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                        iresp_q      <= (grant_q == GNT_ICACHE);
                        dresp_q      <= (grant_q == GNT_DCACHE);
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    iresp_q <= 1'b0;
                    dresp_q <= 1'b0;
                    grant_q <= GNT_NONE;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    line_burst_adapter #(
        .LINE_BITS   (LINE_BITS),
        .BEAT_BITS   (BEAT_BITS),
        .BURST_BEATS (BURST_BEATS)
    ) u_adapter (
        .clk          (clk),
        .rst          (rst),
        .load_i       ((state_q == IDLE) && any_req),
        .beat_i       (in_burst && pmem_resp),
        .capture_i    ((state_q == RD_BURST) && pmem_resp),
        .wdata_i      (sel_wdata),
        .rdata_beat_i (pmem_rdata),
        .wdata_beat_o (pmem_wdata),
        .line_o       (line_buf),
        .last_beat_o  (last_beat)
    );

    assign pmem_read     = pmem_read_q;
    assign pmem_write    = pmem_write_q;
    assign pmem_addr     = addr_q;
    assign icache.resp   = iresp_q;
    assign dcache.resp   = dresp_q;
    assign icache.rdata  = line_buf;
    assign dcache.rdata  = line_buf;

    // Byte masks are not honoured: lines always move whole.
    logic unused_wmask;
    assign unused_wmask = ^{icache.wmask, dcache.wmask};

endmodule
